// File: rtl/pipe_stage_reg.sv
// Pipeline stage register for a hazard-aware in-order core.
// Carries PC, instruction word, destination register, Tnew and
// N_DATA 32-bit data lanes between stages. Supports load, stall (hold)
// and flush (bubble insertion), plus a saturating occupancy age counter.
// Every output comes straight from a register.

module pipe_stage_reg #(
    parameter int          N_DATA         = 2,
    parameter int          TNEW_W         = 2,
    parameter bit          DEC_TNEW       = 1'b1,
    parameter logic [31:0] INIT_PC        = 32'h0000_3000,
    parameter bit          KEEP_PC_ON_CLR = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    input  logic [4:0]             in_a3,
    input  logic [TNEW_W-1:0]      in_tnew,
    input  logic [32*N_DATA-1:0]   in_data,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic [4:0]             out_a3,
    output logic [TNEW_W-1:0]      out_tnew,
    output logic [32*N_DATA-1:0]   out_data,
    output logic [7:0]             out_age
);

    localparam int                DW        = 32 * N_DATA;
    localparam logic [TNEW_W-1:0] TNEW_ZERO = {TNEW_W{1'b0}};
    localparam logic [7:0]        AGE_MAX   = 8'hFF;

    // State registers start at their reset values so the outputs are
    // defined from time zero, before the first reset edge.
    logic                valid_r = 1'b0;
    logic [31:0]         pc_r    = INIT_PC;
    logic [31:0]         instr_r = 32'h0000_0000;
    logic [4:0]          a3_r    = 5'd0;
    logic [TNEW_W-1:0]   tnew_r  = {TNEW_W{1'b0}};
    logic [DW-1:0]       data_r  = {DW{1'b0}};
    logic [7:0]          age_r   = 8'd0;

    logic                valid_s;
    logic [31:0]         pc_s;
    logic [31:0]         instr_s;
    logic [4:0]          a3_s;
    logic [TNEW_W-1:0]   tnew_s;
    logic [DW-1:0]       data_s;
    logic [7:0]          age_s;

    // Tnew seen by the next stage on a load. A bubble or a $0 destination
    // can never be a hazard source, so those carry Tnew=0. Otherwise the
    // value ages by one cycle (saturating at 0) when decrement is enabled.
    function automatic logic [TNEW_W-1:0] load_tnew(
        input logic              valid,
        input logic [4:0]        a3,
        input logic [TNEW_W-1:0] tnew
    );
        logic [TNEW_W-1:0] res;
        if (!valid || (a3 == 5'd0)) begin
            res = TNEW_ZERO;
        end else if ((DEC_TNEW == 1'b1) && (tnew != TNEW_ZERO)) begin
            res = tnew - TNEW_W'(1'b1);
        end else begin
            res = tnew;
        end
        return res;
    endfunction

    // Saturating age increment used while the stage is stalled.
    function automatic logic [7:0] age_inc(input logic [7:0] age);
        logic [7:0] res;
        if (age != AGE_MAX) begin
            res = age + 8'd1;
        end else begin
            res = age;
        end
        return res;
    endfunction

    // Next-state selection: flush beats stall, stall beats load.
    always_comb begin
        valid_s = valid_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        a3_s    = a3_r;
        tnew_s  = tnew_r;
        data_s  = data_r;
        age_s   = age_r;
        if (clr) begin
            valid_s = 1'b0;
            pc_s    = (KEEP_PC_ON_CLR == 1'b1) ? in_pc : INIT_PC;
            instr_s = 32'h0000_0000;
            a3_s    = 5'd0;
            tnew_s  = TNEW_ZERO;
            data_s  = {DW{1'b0}};
            age_s   = 8'd0;
        end else if (!en) begin
            age_s   = age_inc(age_r);
        end else begin
            valid_s = in_valid;
            pc_s    = in_pc;
            instr_s = in_instr;
            a3_s    = in_valid ? in_a3 : 5'd0;
            tnew_s  = load_tnew(in_valid, in_a3, in_tnew);
            data_s  = in_data;
            age_s   = 8'd0;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            pc_r    <= INIT_PC;
            instr_r <= 32'h0000_0000;
            a3_r    <= 5'd0;
            tnew_r  <= TNEW_ZERO;
            data_r  <= {DW{1'b0}};
            age_r   <= 8'd0;
        end else begin
            valid_r <= valid_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            a3_r    <= a3_s;
            tnew_r  <= tnew_s;
            data_r  <= data_s;
            age_r   <= age_s;
        end
    end

    assign out_valid = valid_r;
    assign out_pc    = pc_r;
    assign out_instr = instr_r;
    assign out_a3    = a3_r;
    assign out_tnew  = tnew_r;
    assign out_data  = data_r;
    assign out_age   = age_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg. Two instances share
// the same stimulus: dut uses the defaults (decrementing Tnew, flush PC
// = INIT_PC); dut_k keeps Tnew unchanged and keeps in_pc on flush.

module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, clr, in_valid;
    logic [31:0] in_pc, in_instr;
    logic [4:0]  in_a3;
    logic [1:0]  in_tnew;
    logic [63:0] in_data;

    logic        o_valid, k_valid;
    logic [31:0] o_pc, k_pc, o_instr, k_instr;
    logic [4:0]  o_a3, k_a3;
    logic [1:0]  o_tnew, k_tnew;
    logic [63:0] o_data, k_data;
    logic [7:0]  o_age, k_age;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_a3(in_a3), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(o_valid), .out_pc(o_pc), .out_instr(o_instr),
        .out_a3(o_a3), .out_tnew(o_tnew), .out_data(o_data), .out_age(o_age)
    );

    pipe_stage_reg #(.DEC_TNEW(1'b0), .KEEP_PC_ON_CLR(1'b1)) dut_k (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_a3(in_a3), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(k_valid), .out_pc(k_pc), .out_instr(k_instr),
        .out_a3(k_a3), .out_tnew(k_tnew), .out_data(k_data), .out_age(k_age)
    );

    typedef struct {
        logic        en, clr, valid;
        logic [31:0] pc, instr;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic [63:0] data;
        logic        e_valid;
        logic [31:0] e_pc, e_pc_k, e_instr;
        logic [4:0]  e_a3;
        logic [1:0]  e_tnew, e_tnew_k;
        logic [63:0] e_data;
        logic [7:0]  e_age;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic c, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [4:0] a3, input logic [1:0] tn,
                         input logic [63:0] d);
        en = e; clr = c; in_valid = v; in_pc = pc; in_instr = ins;
        in_a3 = a3; in_tnew = tn; in_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"},   {63'd0, o_valid}, 64'd0);
        chk({tag, ".pc"},      {32'd0, o_pc},    64'h3000);
        chk({tag, ".pc_k"},    {32'd0, k_pc},    64'h3000);
        chk({tag, ".instr"},   {32'd0, o_instr}, 64'd0);
        chk({tag, ".a3"},      {59'd0, o_a3},    64'd0);
        chk({tag, ".tnew"},    {62'd0, o_tnew},  64'd0);
        chk({tag, ".tnew_k"},  {62'd0, k_tnew},  64'd0);
        chk({tag, ".data"},    o_data,           64'd0);
        chk({tag, ".age"},     {56'd0, o_age},   64'd0);
        chk({tag, ".age_k"},   {56'd0, k_age},   64'd0);
    endtask

    initial begin
        // en clr v  pc  instr  a3 tnew data | valid pc pc_k instr a3 tnew tnew_k data age
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h3000, 32'hAAAA_0001, 5'd5, 2'd2, {32'hB, 32'hA},
                     1'b1, 32'h3000, 32'h3000, 32'hAAAA_0001, 5'd5, 2'd1, 2'd2, {32'hB, 32'hA}, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h3004, 32'h0000_0002, 5'd8, 2'd0, {32'hD, 32'hC},
                     1'b1, 32'h3004, 32'h3004, 32'h0000_0002, 5'd8, 2'd0, 2'd0, {32'hD, 32'hC}, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h3008, 32'h0000_0003, 5'd0, 2'd2, {32'h0, 32'h9},
                     1'b1, 32'h3008, 32'h3008, 32'h0000_0003, 5'd0, 2'd0, 2'd0, {32'h0, 32'h9}, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h300C, 32'h0000_0004, 5'd7, 2'd3, {32'hF, 32'hE},
                     1'b0, 32'h300C, 32'h300C, 32'h0000_0004, 5'd0, 2'd0, 2'd0, {32'hF, 32'hE}, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h3004, 32'h0000_0005, 5'd3, 2'd3, {32'h2, 32'h1},
                     1'b1, 32'h3004, 32'h3004, 32'h0000_0005, 5'd3, 2'd2, 2'd3, {32'h2, 32'h1}, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h3100, 32'h0000_0099, 5'd9, 2'd1, {32'h7, 32'h7},
                     1'b1, 32'h3004, 32'h3004, 32'h0000_0005, 5'd3, 2'd2, 2'd3, {32'h2, 32'h1}, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h3200, 32'h0000_0098, 5'd0, 2'd0, {32'h8, 32'h8},
                     1'b1, 32'h3004, 32'h3004, 32'h0000_0005, 5'd3, 2'd2, 2'd3, {32'h2, 32'h1}, 8'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h3300, 32'h0000_0097, 5'd4, 2'd3, {32'h9, 32'h9},
                     1'b1, 32'h3004, 32'h3004, 32'h0000_0005, 5'd3, 2'd2, 2'd3, {32'h2, 32'h1}, 8'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h3010, 32'h0000_0096, 5'd6, 2'd2, {32'h5, 32'h5},
                     1'b0, 32'h3000, 32'h3010, 32'h0000_0000, 5'd0, 2'd0, 2'd0, 64'd0, 8'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h3020, 32'h0000_0095, 5'd6, 2'd2, {32'h5, 32'h5},
                     1'b0, 32'h3000, 32'h3020, 32'h0000_0000, 5'd0, 2'd0, 2'd0, 64'd0, 8'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h3030, 32'h0000_0006, 5'd31, 2'd1, {32'hFFFF_FFFF, 32'h1234_5678},
                     1'b1, 32'h3030, 32'h3030, 32'h0000_0006, 5'd31, 2'd0, 2'd1, {32'hFFFF_FFFF, 32'h1234_5678}, 8'd0};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 64'd0);

        // Time-zero values, before any clock edge.
        #1;
        chk_reset_vals("t0");

        // Explicit reset.
        reset = 1'b1;
        step();
        chk_reset_vals("rst");
        reset = 1'b0;

        // Table of single-edge vectors.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].valid, vecs[i].pc, vecs[i].instr,
                  vecs[i].a3, vecs[i].tnew, vecs[i].data);
            step();
            chk($sformatf("v%0d.valid", i),   {63'd0, o_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d.valid_k", i), {63'd0, k_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d.pc", i),      {32'd0, o_pc},    {32'd0, vecs[i].e_pc});
            chk($sformatf("v%0d.pc_k", i),    {32'd0, k_pc},    {32'd0, vecs[i].e_pc_k});
            chk($sformatf("v%0d.instr", i),   {32'd0, o_instr}, {32'd0, vecs[i].e_instr});
            chk($sformatf("v%0d.a3", i),      {59'd0, o_a3},    {59'd0, vecs[i].e_a3});
            chk($sformatf("v%0d.a3_k", i),    {59'd0, k_a3},    {59'd0, vecs[i].e_a3});
            chk($sformatf("v%0d.tnew", i),    {62'd0, o_tnew},  {62'd0, vecs[i].e_tnew});
            chk($sformatf("v%0d.tnew_k", i),  {62'd0, k_tnew},  {62'd0, vecs[i].e_tnew_k});
            chk($sformatf("v%0d.lane0", i),   {32'd0, o_data[31:0]},  {32'd0, vecs[i].e_data[31:0]});
            chk($sformatf("v%0d.lane1", i),   {32'd0, o_data[63:32]}, {32'd0, vecs[i].e_data[63:32]});
            chk($sformatf("v%0d.data_k", i),  k_data,           vecs[i].e_data);
            chk($sformatf("v%0d.age", i),     {56'd0, o_age},   {56'd0, vecs[i].e_age});
        end

        // Hold until age reaches 200, then reset for one edge while stalled.
        drive(1'b0, 1'b0, 1'b1, 32'h3040, 32'h0000_0011, 5'd2, 2'd2, 64'h1);
        for (int i = 0; i < 200; i++) step();
        chk("age200", {56'd0, o_age}, 64'd200);
        chk("hold.pc", {32'd0, o_pc}, 64'h3030);
        reset = 1'b1;
        step();
        chk_reset_vals("rst_hold");

        // Reset overrides a simultaneous flush (dut_k would otherwise take in_pc).
        clr = 1'b1;
        in_pc = 32'h3050;
        step();
        chk_reset_vals("rst_flush");
        reset = 1'b0;
        clr = 1'b0;

        // First load after reset is accepted on the first edge.
        drive(1'b1, 1'b0, 1'b1, 32'h3060, 32'h0000_0012, 5'd4, 2'd1, {32'h22, 32'h11});
        step();
        chk("post_rst.valid", {63'd0, o_valid}, 64'd1);
        chk("post_rst.pc",    {32'd0, o_pc},    64'h3060);
        chk("post_rst.tnew",  {62'd0, o_tnew},  64'd0);
        chk("post_rst.tnew_k",{62'd0, k_tnew},  64'd1);
        chk("post_rst.data",  o_data,           {32'h22, 32'h11});

        // Long stall: age saturates at 255 without wrapping.
        en = 1'b0;
        for (int i = 0; i < 254; i++) step();
        chk("age254", {56'd0, o_age}, 64'd254);
        step();
        chk("age255", {56'd0, o_age}, 64'd255);
        for (int i = 0; i < 45; i++) step();
        chk("age_sat", {56'd0, o_age}, 64'd255);
        chk("age_sat_k", {56'd0, k_age}, 64'd255);
        chk("sat.pc", {32'd0, o_pc}, 64'h3060);

        // Load after saturation clears the age.
        en = 1'b1;
        step();
        chk("age_clr", {56'd0, o_age}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_DATA, 2: number of 32-bit data lanes carried (1..4).
- TNEW_W, 2: Tnew field width.
- DEC_TNEW, 1: 1 = saturating decrement of Tnew on load; 0 = pass through.
- INIT_PC, 32'h0000_3000: PC value after reset or flush.
- KEEP_PC_ON_CLR, 0: 1 = flush bubble carries in_pc instead of INIT_PC.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: load enable; 0 = hold (stall).
- clr, in, 1: flush; inserts a bubble.
- in_valid, in, 1: upstream slot holds a real instruction.
- in_pc, in, 32: instruction address.
- in_instr, in, 32: instruction word.
- in_a3, in, 5: destination register.
- in_tnew, in, TNEW_W: cycles until result is ready, as seen upstream.
- in_data, in, 32*N_DATA: data lanes, lane k at bits [32k+31:32k].
- out_valid, out, 1: registered valid.
- out_pc, out, 32: registered PC.
- out_instr, out, 32: registered instruction word.
- out_a3, out, 5: registered destination register.
- out_tnew, out, TNEW_W: registered Tnew.
- out_data, out, 32*N_DATA: registered data lanes.
- out_age, out, 8: cycles the current contents have been held.

REQ-003 All outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Function
REQ-004 Update priority at each rising clk edge SHALL be: reset > clr > (en==0 hold) > load.
REQ-005 Load (en=1, clr=0) SHALL capture all in_* fields into the corresponding out_* registers with 1-cycle latency.
REQ-006 On load with DEC_TNEW=1, out_tnew SHALL be in_tnew-1, saturating at 0; with DEC_TNEW=0, out_tnew SHALL equal in_tnew.
REQ-007 On load with in_valid=0, the bubble rule SHALL apply: out_a3=0 and out_tnew=0, other fields captured as-is.
REQ-008 On load with in_valid=1 and in_a3=0, out_tnew SHALL be forced to 0, since $0 is never a hazard source.
REQ-009 Hold (en=0, clr=0) SHALL keep every out_* field unchanged, including out_tnew; Tnew does not age while stalled.
REQ-010 Flush (clr=1) SHALL produce a bubble regardless of en:
- out_valid=0, out_instr=0, out_a3=0, out_tnew=0, out_data=0.
- out_pc=in_pc if KEEP_PC_ON_CLR=1, else INIT_PC.
REQ-011 out_age SHALL behave as follows:
- cleared to 0 on reset, flush or load;
- incremented by 1 on each hold cycle;
- saturates at 255 (no wrap).
REQ-012 Simultaneous clr=1 and en=0 SHALL flush; clr overrides stall.
REQ-013 Lane ordering SHALL be preserved exactly for every N_DATA; unused lanes do not exist (no padding).
REQ-014 The block SHALL contain no decode logic; Tnew is supplied by the upstream stage.

Reset
REQ-015 While reset=1 at a clk edge, outputs SHALL take these values:
- out_valid=0, out_pc=INIT_PC, out_instr=0, out_a3=0;
- out_tnew=0, out_data=0, out_age=0.
REQ-016 Reset asserted mid-hold or mid-flush SHALL override both; the first load is accepted on the first edge after reset falls.
REQ-017 Registers SHALL also hold the REQ-015 values at time zero (simulation initialisation).

Verification
REQ-018 Load with DEC_TNEW=1, N_DATA=2:
- stimulus: in_tnew=2, in_a3=5, in_valid=1, in_data={32'hB,32'hA}, one edge;
- response: out_tnew=1, out_a3=5, out_data[31:0]=32'hA, out_data[63:32]=32'hB.
REQ-019 Saturation:
- stimulus: in_tnew=0, in_a3=8, in_valid=1, load;
- response: out_tnew=0, not wrapped to 3.
REQ-020 Stall:
- stimulus: load in_pc=32'h3004, then en=0 for 3 edges while inputs change;
- response: out_pc stays 32'h3004, out_tnew unchanged, out_age=1,2,3.
REQ-021 Flush over stall:
- stimulus: clr=1, en=0, in_pc=32'h3010, KEEP_PC_ON_CLR=0;
- response: out_valid=0, out_a3=0, out_pc=32'h0000_3000.
- stimulus: same with KEEP_PC_ON_CLR=1;
- response: out_pc=32'h3010.
REQ-022 $0 destination and invalid slot:
- stimulus: in_valid=1, in_a3=0, in_tnew=2;
- response: out_tnew=0.
- stimulus: in_valid=0, in_a3=7;
- response: out_a3=0.
REQ-023 Reset during hold:
- stimulus: out_age=200, reset=1 for 1 edge;
- response: all outputs equal REQ-015 values.
- stimulus: 300 consecutive hold cycles;
- response: out_age saturates at 255.
